// File: rtl/asynchronous_fifo.sv
// asynchronous_fifo
//   Single-clock FIFO buffer between a producer and a consumer, both on clk1.
//   Storage is a DEPTH x DATA_WIDTH register array with a registered read port.
//   The FIFO reports full/empty status and almost_full/almost_empty flags for flow control.
//
// Ports
//   clk1          in   1           clock; all state updates on the rising edge
//   wrst_n        in   1           synchronous reset, active HIGH (the name is historical)
//   wr_en         in   1           write request, accepted when not full
//   rd_en         in   1           read request, accepted when not empty
//   din           in   DATA_WIDTH  write data
//   dout          out  DATA_WIDTH  read data, valid the edge after an accepted read, else held
//   full          out  1           occupancy == DEPTH
//   empty         out  1           occupancy == 0
//   almost_full   out  1           occupancy >= AFULL_THRESH
//   almost_empty  out  1           occupancy <= AEMPTY_THRESH
module asynchronous_fifo #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int ADDR_WIDTH    = 4,
   parameter int AFULL_THRESH  = 14,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk1,
   input  logic                  wrst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam int PW = ADDR_WIDTH + 1;

   // Thresholds and the unit increment are sized to the pointer/count width
   // so every compare and add is width-exact.
   localparam logic [PW-1:0] AFULL_L  = AFULL_THRESH[PW-1:0];
   localparam logic [PW-1:0] AEMPTY_L = AEMPTY_THRESH[PW-1:0];
   localparam logic [PW-1:0] ONE_L    = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         count_q,  count_d;
   logic [DATA_WIDTH-1:0] dout_q,   dout_d;

   logic                  full_c;
   logic                  empty_c;
   logic                  wr_accept;
   logic                  rd_accept;

   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH-1:0] rd_addr;

   assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
   assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

   // The extra pointer MSB separates "same slot, one lap ahead" (full)
   // from "same slot, same lap" (empty).
   assign full_c  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) && (wr_addr == rd_addr);
   assign empty_c = (wr_ptr_q == rd_ptr_q);

   // Gating by the registered flags means that a write and a read requested
   // together on an empty FIFO only write, and on a full FIFO only read.
   assign wr_accept = wr_en & ~full_c;
   assign rd_accept = rd_en & ~empty_c;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;

      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + ONE_L;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + ONE_L;
         dout_d   = mem[rd_addr];
      end

      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + ONE_L;
         2'b01:   count_d = count_q - ONE_L;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (wrst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   // Storage is deliberately left out of reset; a reset makes the old
   // contents unreachable by clearing the pointers instead.
   always_ff @(posedge clk1) begin
      if (!wrst_n && wr_accept) begin
         mem[wr_addr] <= din;
      end
   end

   assign dout         = dout_q;
   assign full         = full_c;
   assign empty        = empty_c;
   assign almost_full  = (count_q >= AFULL_L);
   assign almost_empty = (count_q <= AEMPTY_L);

endmodule

// File: tb/tb_asynchronous_fifo.sv
// tb_asynchronous_fifo
//   Directed scenario tasks plus a queue-model random run for asynchronous_fifo.
//   Inputs change 1 time unit after a rising edge; outputs are checked at the
//   same point, i.e. after the edge that consumed the previous inputs.
module tb_asynchronous_fifo;

   logic       clk1;
   logic       wrst_n;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] din;
   logic [7:0] dout;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;

   int checks;
   int errors;

   logic [7:0] model_q[$];
   logic [7:0] model_dout;

   asynchronous_fifo #(
      .DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
   ) dut (
      .clk1(clk1), .wrst_n(wrst_n), .wr_en(wr_en), .rd_en(rd_en), .din(din),
      .dout(dout), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic test_reset();
      wrst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
      tick();
      tick();
      wrst_n = 1'b0;
      tick();
      checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
      checks++; if (full !== 1'b0)         begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (almost_full !== 1'b0)  begin errors++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
      checks++; if (dout !== 8'h00)        begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
      $display("test_reset: idle after reset checked");
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1; din = 8'(i);
         tick();
         checks++; if (almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_aempty n=%0d got=%b exp=%b", i, almost_empty, (i <= 2)); end
         checks++; if (almost_full !== (i >= 14)) begin errors++; $display("FAIL fill_afull n=%0d got=%b exp=%b", i, almost_full, (i >= 14)); end
         checks++; if (full !== (i == 16))        begin errors++; $display("FAIL fill_full n=%0d got=%b exp=%b", i, full, (i == 16)); end
         checks++; if (empty !== 1'b0)            begin errors++; $display("FAIL fill_empty n=%0d got=%b exp=0", i, empty); end
         $display("test_fill: write %0d din=%h full=%b afull=%b aempty=%b", i, din, full, almost_full, almost_empty);
      end
      // 17th write into a full FIFO must be dropped; the drain test proves
      // 0xFF never appears in the data stream.
      din = 8'hFF;
      tick();
      wr_en = 1'b0;
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_overflow_full got=%b exp=1", full); end
      $display("test_fill: overflow write of ff ignored, full=%b", full);
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 16; i++) begin
         rd_en = 1'b1;
         tick();
         checks++; if (dout !== 8'(i)) begin errors++; $display("FAIL drain_dout n=%0d got=%h exp=%h", i, dout, 8'(i)); end
         checks++; if (full !== 1'b0)  begin errors++; $display("FAIL drain_full n=%0d got=%b exp=0", i, full); end
         $display("test_drain: read %0d dout=%h", i, dout);
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
      tick();
      rd_en = 1'b0;
      checks++; if (dout !== 8'h10) begin errors++; $display("FAIL drain_underflow_dout got=%h exp=10", dout); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_underflow_empty got=%b exp=1", empty); end
      $display("test_drain: extra read on empty, dout=%h", dout);
   endtask

   task automatic test_simultaneous();
      logic [7:0] next_val;
      logic [7:0] exp;
      next_val = 8'h20;
      model_q.delete();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; din = next_val;
         model_q.push_back(next_val);
         next_val++;
         tick();
      end
      // Pointers start at 16 here, so 40 more cycles cross the 2*DEPTH wrap.
      rd_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         din = next_val;
         exp = model_q.pop_front();
         model_q.push_back(next_val);
         next_val++;
         tick();
         checks++; if (dout !== exp) begin errors++; $display("FAIL simul_dout cyc=%0d got=%h exp=%h", i, dout, exp); end
         checks++; if ({full, empty, almost_full, almost_empty} !== 4'b0000) begin
            errors++; $display("FAIL simul_flags cyc=%0d got=%b exp=0000", i, {full, empty, almost_full, almost_empty});
         end
         $display("test_simultaneous: cyc %0d din=%h dout=%h", i, din, dout);
      end
      wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp = model_q.pop_front();
         tick();
         checks++; if (dout !== exp) begin errors++; $display("FAIL simul_drain n=%0d got=%h exp=%h", i, dout, exp); end
         $display("test_simultaneous: drain %0d dout=%h", i, dout);
      end
      rd_en = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_final_empty got=%b exp=1", empty); end
      model_dout = exp;
   endtask

   task automatic test_empty_rw();
      wr_en = 1'b1; rd_en = 1'b1; din = 8'hA5;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      checks++; if (empty !== 1'b0)     begin errors++; $display("FAIL emptyrw_empty got=%b exp=0", empty); end
      checks++; if (dout !== model_dout) begin errors++; $display("FAIL emptyrw_dout_hold got=%h exp=%h", dout, model_dout); end
      $display("test_empty_rw: wr+rd on empty, dout=%h empty=%b", dout, empty);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL emptyrw_read got=%h exp=a5", dout); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL emptyrw_after_empty got=%b exp=1", empty); end
      $display("test_empty_rw: read back dout=%h", dout);
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; din = 8'h30 + 8'(i);
         tick();
      end
      checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL midrst_pre_aempty got=%b exp=0", almost_empty); end
      // Reset must win over simultaneous requests.
      wrst_n = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 8'h99;
      tick();
      wrst_n = 1'b0; wr_en = 1'b0;
      checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL midrst_empty got=%b exp=1", empty); end
      checks++; if (dout !== 8'h00)        begin errors++; $display("FAIL midrst_dout got=%h exp=00", dout); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL midrst_aempty got=%b exp=1", almost_empty); end
      $display("test_mid_reset: reset with 8 held, empty=%b dout=%h", empty, dout);
      tick();
      rd_en = 1'b0;
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_stale_read got=%h exp=00", dout); end
      wr_en = 1'b1; din = 8'h77;
      tick();
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      checks++; if (dout !== 8'h77) begin errors++; $display("FAIL midrst_new_data got=%h exp=77", dout); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_new_empty got=%b exp=1", empty); end
      $display("test_mid_reset: post-reset write/read dout=%h", dout);
      model_dout = 8'h77;
   endtask

   task automatic test_random();
      int wp;
      int cnt;
      logic wacc;
      logic racc;
      model_q.delete();
      for (int t = 0; t < 600; t++) begin
         // Write-heavy first half, read-heavy second half, so both
         // full and empty boundaries are exercised.
         wp = (t < 300) ? 70 : 30;
         wr_en = ($urandom_range(0, 99) < wp);
         rd_en = ($urandom_range(0, 99) < 100 - wp);
         din   = 8'($urandom);
         cnt   = model_q.size();
         wacc  = wr_en && (cnt < 16);
         racc  = rd_en && (cnt > 0);
         if (racc) model_dout = model_q.pop_front();
         if (wacc) model_q.push_back(din);
         tick();
         cnt = model_q.size();
         checks++; if (dout !== model_dout) begin errors++; $display("FAIL rand_dout t=%0d got=%h exp=%h", t, dout, model_dout); end
         checks++; if ({full, empty, almost_full, almost_empty} !== {cnt == 16, cnt == 0, cnt >= 14, cnt <= 2}) begin
            errors++;
            $display("FAIL rand_flags t=%0d got=%b exp=%b", t, {full, empty, almost_full, almost_empty},
                     {cnt == 16, cnt == 0, cnt >= 14, cnt <= 2});
         end
         $display("test_random: t=%0d wr=%b rd=%b din=%h dout=%h cnt=%0d", t, wr_en, rd_en, din, dout, cnt);
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_dout = 8'h00;
      test_reset();
      test_fill();
      test_drain();
      test_simultaneous();
      test_empty_rw();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
